// File: rtl/line_pkg.sv
// Shared widths, coordinate limits and FSM state type for the line drawer.
package line_pkg;

  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned COL_W = 3;
  localparam int unsigned ERR_W = 11;

  localparam int unsigned X_MAX = 335;
  localparam int unsigned Y_MAX = 209;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone
  } state_t;

endpackage

// File: rtl/line_drawer.sv
// Bresenham line drawer emitting one pixel per accepted DRAW cycle.
// Define LINE_DRAWER_STALL_EN to add a vga_ready handshake from the framebuffer.
module line_drawer
  import line_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y1,
  input  logic [COL_W-1:0] colour,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot
`ifdef LINE_DRAWER_STALL_EN
  ,
  input  logic             vga_ready
`endif
);

  state_t state_q, state_d;

  logic [X_W-1:0]          x_q, x1_q;
  logic [Y_W-1:0]          y_q, y1_q;
  logic [COL_W-1:0]        col_q;
  logic signed [ERR_W-1:0] dx_q, dy_q, err_q;
  logic                    sx_neg_q, sy_neg_q;

  logic ready;
`ifdef LINE_DRAWER_STALL_EN
  assign ready = vga_ready;
`else
  assign ready = 1'b1;
`endif

  // Setup arithmetic on the raw command inputs, used only in the start cycle.
  logic signed [ERR_W-1:0] ddx, ddy, dx_abs, dy_neg;
  assign ddx    = $signed(ERR_W'(x1)) - $signed(ERR_W'(x0));
  assign ddy    = $signed(ERR_W'(y1)) - $signed(ERR_W'(y0));
  assign dx_abs = ddx[ERR_W-1] ? -ddx : ddx;
  assign dy_neg = ddy[ERR_W-1] ? ddy : -ddy;

  // Both axis decisions compare against the pre-step error.
  logic signed [ERR_W-1:0] e2, add_x, add_y, err_step;
  logic                    step_x, step_y;
  assign e2       = err_q <<< 1;
  assign step_x   = (e2 >= dy_q);
  assign step_y   = (e2 <= dx_q);
  assign add_x    = step_x ? dy_q : '0;
  assign add_y    = step_y ? dx_q : '0;
  assign err_step = err_q + add_x + add_y;

  logic accept, at_end;
  assign accept = (state_q == StDraw) && ready;
  assign at_end = (x_q == x1_q) && (y_q == y1_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StDraw;
      StDraw: if (accept && at_end) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      col_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        x_q      <= x0;
        y_q      <= y0;
        x1_q     <= x1;
        y1_q     <= y1;
        col_q    <= colour;
        dx_q     <= dx_abs;
        dy_q     <= dy_neg;
        err_q    <= dx_abs + dy_neg;
        sx_neg_q <= ddx[ERR_W-1];
        sy_neg_q <= ddy[ERR_W-1];
      end else if (accept && !at_end) begin
        err_q <= err_step;
        if (step_x) x_q <= sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
        if (step_y) y_q <= sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
      end
    end
  end

  // Pixel outputs come straight from the point registers, so they hold outside DRAW.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    vga_plot   = 1'b0;
    vga_x      = x_q;
    vga_y      = y_q;
    vga_colour = col_q;
    unique case (state_q)
      StIdle: ;
      StDraw: begin
        busy     = 1'b1;
        vga_plot = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_drawer.sv
// Randomised and directed self-checking bench for line_drawer against a Bresenham reference.
module tb_line_drawer;
  import line_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [X_W-1:0]   x0 = '0, x1 = '0;
  logic [Y_W-1:0]   y0 = '0, y1 = '0;
  logic [COL_W-1:0] colour = '0;
  logic             busy, done, vga_plot;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  line_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .colour     (colour),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
`ifdef LINE_DRAWER_STALL_EN
    ,
    .vga_ready  (vga_ready)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: textbook integer Bresenham producing the full pixel list.
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_x.delete();
    exp_y.delete();
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    x   = ax0;
    y   = ay0;
    for (int guard = 0; guard < 1000; guard++) begin
      exp_x.push_back(x);
      exp_y.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // smode: 0 ready always, 1 random ready, 2 ready low for 3 cycles on the second pixel.
  task automatic draw_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int acol, input bit poke, input int smode);
    int n, idx, busy_cnt, done_cyc, stall_left, adx, ady;
    bit got_done, stall_used;
    build_model(ax0, ay0, ax1, ay1);
    n   = exp_x.size();
    adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    check("model_len", n, ((adx > ady) ? adx : ady) + 1);
    idx = 0; busy_cnt = 0; done_cyc = 0; stall_left = 0;
    got_done = 1'b0; stall_used = 1'b0;
    @(negedge clk);
    x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
    colour = COL_W'(acol); start = 1'b1; vga_ready = 1'b1;
    for (int c = 1; c <= 3000 && !got_done; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1'b1;
        done_cyc = c;
        check("done_plot", vga_plot, 0);
        check("done_npix", idx, n);
      end else if (vga_plot) begin
        if (idx < n) begin
          check("px_x", vga_x, exp_x[idx]);
          check("px_y", vga_y, exp_y[idx]);
          check("px_col", vga_colour, acol);
        end else begin
          check("px_overrun", idx, n - 1);
        end
        if (vga_ready) idx++;
      end else begin
        check("draw_gap_busy", busy, 0);
        check("draw_gap_plot", vga_plot, 1);
      end
      if (c == 1) begin
        start = 1'b0;
        x0 = X_W'($urandom_range(X_MAX)); y0 = Y_W'($urandom_range(Y_MAX));
        x1 = X_W'($urandom_range(X_MAX)); y1 = Y_W'($urandom_range(Y_MAX));
        colour = COL_W'($urandom);
      end
      if (poke && c == 2) start = 1'b1;
      if (poke && c == 3) start = 1'b0;
      if (smode == 2 && idx == 1 && !stall_used) begin
        stall_used = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        vga_ready = 1'b0;
        stall_left--;
      end else if (smode == 1) begin
        vga_ready = ($urandom_range(3) != 0);
      end else begin
        vga_ready = 1'b1;
      end
    end
    start = 1'b0;
    vga_ready = 1'b1;
    check("done_seen", got_done, 1);
    if (smode == 0) begin
      check("done_cycle", done_cyc, n + 1);
      check("busy_len", busy_cnt, n + 1);
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_plot", vga_plot, 0);
    check("idle_hold_x", vga_x, exp_x[n-1]);
    check("idle_hold_y", vga_y, exp_y[n-1]);
  endtask

  task automatic reset_mid_line();
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 10; y1 = 0; colour = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_third_px", vga_x, 2);
    check("rst_third_plot", vga_plot, 1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", vga_x, 0);
    check("rst_col", vga_colour, 0);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
      check("rst_no_busy", busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_plot", vga_plot, 0);
    check("reset_x", vga_x, 0);
    check("reset_y", vga_y, 0);
    check("reset_col", vga_colour, 0);
    reset = 1'b0;

    draw_line(0, 0, 3, 0, 5, 1'b0, 0);
    draw_line(0, 0, 1, 3, 2, 1'b0, 0);
    draw_line(5, 5, 2, 2, 1, 1'b0, 0);
    draw_line(7, 9, 7, 9, 4, 1'b0, 0);
    draw_line(20, 30, 2, 40, 7, 1'b1, 0);
    draw_line(X_MAX, Y_MAX, 0, 0, 3, 1'b0, 0);
    reset_mid_line();
    draw_line(4, 4, 9, 1, 2, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      draw_line($urandom_range(X_MAX), $urandom_range(Y_MAX), $urandom_range(X_MAX),
                $urandom_range(Y_MAX), $urandom_range(7), ($urandom_range(1) == 1), 0);
    end

`ifdef LINE_DRAWER_STALL_EN
    draw_line(0, 0, 3, 0, 5, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      draw_line($urandom_range(60), $urandom_range(60), $urandom_range(60),
                $urandom_range(60), $urandom_range(7), 1'b0, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_drawer.md
LINE_DRAWER -- requirements
Module: line_drawer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-002 SHALL have these command inputs from the line-drawing control datapath:
- start  input  1  single-cycle draw request.
- x0  input  9  start x, 0..335.
- y0  input  8  start y, 0..209.
- x1  input  9  end x, 0..335.
- y1  input  8  end y, 0..209.
- colour  input  3  pixel colour.
REQ-003 SHALL have these status outputs:
- busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  output  1  one-cycle completion pulse.
REQ-004 SHALL have these pixel outputs to the VGA framebuffer:
- vga_x  output  9  pixel x.
- vga_y  output  8  pixel y.
- vga_colour  output  3  pixel colour.
- vga_plot  output  1  pixel valid.
REQ-005 SHALL add vga_ready (input, 1 bit, framebuffer accepts pixel) only when LINE_DRAWER_STALL_EN is defined.

Function
REQ-006 SHALL implement FSM states IDLE, DRAW and DONE.
REQ-007 IDLE + start=1 SHALL latch x0, y0, x1, y1 and colour, and compute the following, then enter DRAW next cycle:
- dx = |x1-x0|
- dy = -|y1-y0|
- sx/sy = +1 if end >= start, else -1
- err = dx+dy (signed, 11 bits)
REQ-008 SHALL assert vga_plot=1 in every DRAW cycle, with vga_x/vga_y = current point and vga_colour = latched colour; the first pixel SHALL appear one cycle after start.
REQ-009 A pixel SHALL be accepted when vga_plot=1 and vga_ready=1 (vga_ready is taken as 1 without the macro).
REQ-010 On acceptance, if point == (x1,y1), SHALL enter DONE; otherwise SHALL step Bresenham with e2 = 2*err:
- if e2 >= dy: err += dy, x += sx.
- if e2 <= dx: err += dx, y += sy.
- both updates SHALL use the pre-step err.
REQ-011 Without acceptance, all DRAW state and outputs SHALL hold.
REQ-012 DONE SHALL assert done=1 and vga_plot=0 for exactly one cycle, then return to IDLE.
REQ-013 Pixels per line SHALL be max(dx,|dy|)+1; the degenerate case x0=x1, y0=y1 SHALL plot exactly one pixel.
REQ-014 start outside IDLE SHALL be ignored, with no relatch.
REQ-015 Changes on x0..colour after the start cycle SHALL NOT affect the current line.
REQ-016 Outside DRAW, vga_plot SHALL be 0 and vga_x, vga_y, vga_colour SHALL hold their last values.
REQ-017 Arithmetic SHALL use 11-bit signed intermediates; no overflow is possible for in-range coordinates.
REQ-018 Out-of-range inputs are clamped upstream and SHALL NOT be re-checked.

Reset
REQ-019 reset=1 SHALL force the following on the next edge, in any state:
- state = IDLE.
- busy=0, done=0, vga_plot=0.
- vga_x=0, vga_y=0, vga_colour=0.
- internal registers = 0.
REQ-020 Reset mid-line SHALL abort the line with no done pulse.
REQ-021 start concurrent with reset SHALL be ignored.

Configuration
REQ-022 With LINE_DRAWER_STALL_EN defined, the vga_ready port SHALL exist and gate acceptance per REQ-009 to REQ-011.
REQ-023 Without LINE_DRAWER_STALL_EN, the port SHALL be absent and one pixel SHALL be accepted every DRAW cycle.

Structure
REQ-024 A shared package line_pkg SHALL hold:
- X_W=9, Y_W=8, COL_W=3, ERR_W=11.
- X_MAX=335, Y_MAX=209.
- the state enum.
REQ-025 The block SHALL be a single module with no sub-module; the Bresenham step is inline combinational logic.

Verification
REQ-026 Horizontal: start (0,0)->(3,0), colour 5 -> pixels (0,0),(1,0),(2,0),(3,0) on cycles 1-4 after start, colour 5; done on cycle 5.
REQ-027 Steep: (0,0)->(1,3) -> pixels (0,0),(0,1),(1,2),(1,3); busy high for 5 cycles.
REQ-028 Reverse diagonal: (5,5)->(2,2) -> pixels (5,5),(4,4),(3,3),(2,2); done once.
REQ-029 Single point and ignored start: (7,9)->(7,9) -> one pixel (7,9), done next cycle; a start pulsed with other coordinates during busy -> no effect.
REQ-030 Reset during the 3rd pixel of (0,0)->(10,0) -> next cycle vga_plot=0, busy=0, no done; a new start draws normally.
REQ-031 With LINE_DRAWER_STALL_EN: vga_ready=0 for 3 cycles on pixel (1,0) -> vga_x=1 held stable, no advance; line completes correctly when vga_ready returns to 1.
